// File: rtl/onchip_mem_pkg.sv
// Shared types and constants for the on-chip memory stream reader.
// The slave has a registered address and an unregistered q, so its read latency is one clock.
package onchip_mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        FINISH
    } state_t;

    localparam int READ_LATENCY      = 1;
    localparam int MEM_WORDS_DEFAULT = 128000;

endpackage

// File: rtl/mem_reader_fifo.sv
// Small synchronous show-ahead FIFO that buffers read responses ahead of the stream source.
module mem_reader_fifo #(
    parameter int WIDTH = 34,
    parameter int DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CW    = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wrPtr;
    logic [PTR_W-1:0] r_rdPtr;
    logic [CW-1:0]    r_count;
    logic             w_doPush;
    logic             w_doPop;

    // A push into a full FIFO is only accepted when a pop frees a slot in the same cycle.
    assign w_doPop  = i_pop && !o_empty;
    assign w_doPush = i_push && (!o_full || w_doPop);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_doPush) r_wrPtr <= r_wrPtr + PTR_W'(1);
            if (w_doPop)  r_rdPtr <= r_rdPtr + PTR_W'(1);
            case ({w_doPush, w_doPop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_doPush) r_mem[r_wrPtr] <= i_data;
    end

    assign o_data  = r_mem[r_rdPtr];
    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == CW'(DEPTH));
    assign o_count = r_count;

endmodule

// File: rtl/onchip_memory_stream_reader.sv
// Avalon-MM read master that streams a block of consecutive words from on-chip RAM
// out of an Avalon-ST source, with reads throttled so the output FIFO can never overflow.
module onchip_memory_stream_reader
    import onchip_mem_pkg::*;
#(
    parameter int ADDR_W     = 17,
    parameter int DATA_W     = 32,
    parameter int MEM_WORDS  = MEM_WORDS_DEFAULT,
    parameter int CNT_W      = 17,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_start,
    input  logic [ADDR_W-1:0]     i_base_addr,
    input  logic [CNT_W-1:0]      i_word_count,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [ADDR_W-1:0]     o_mem_address,
    output logic                  o_mem_chipselect,
    output logic                  o_mem_clken,
    output logic                  o_mem_write,
    output logic [DATA_W/8-1:0]   o_mem_byteenable,
    output logic [DATA_W-1:0]     o_mem_writedata,
    input  logic [DATA_W-1:0]     i_mem_readdata,
    output logic [DATA_W-1:0]     o_src_data,
    output logic                  o_src_valid,
    input  logic                  i_src_ready,
    output logic                  o_src_sop,
    output logic                  o_src_eop
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int FW = DATA_W + 2;

    if (READ_LATENCY != 1) begin : g_latencyCheck
        $error("onchip_memory_stream_reader tracks a single in-flight read and needs READ_LATENCY=1");
    end

    state_t            r_state;
    state_t            w_nextState;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] w_nextAddr;
    logic [CNT_W-1:0]  r_remain;
    logic              r_first;
    logic              r_inflight;
    logic              r_inflightSop;
    logic              r_inflightEop;
    logic              w_issue;
    logic              w_push;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;
    logic [CW-1:0]     w_count;
    logic [CW:0]       w_outstanding;
    logic [FW-1:0]     w_head;

    // Words already in the FIFO plus the one still returning from the slave.
    assign w_outstanding = {1'b0, w_count} + {{CW{1'b0}}, r_inflight};
    assign w_issue       = (r_state == ISSUE) && (w_outstanding < (CW+1)'(FIFO_DEPTH));
    assign w_nextAddr    = (r_addr == ADDR_W'(MEM_WORDS - 1)) ? '0 : r_addr + ADDR_W'(1);
    assign w_push        = r_inflight && !w_full;
    assign w_pop         = !w_empty && i_src_ready;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state       <= IDLE;
            r_addr        <= '0;
            r_remain      <= '0;
            r_first       <= 1'b0;
            r_inflight    <= 1'b0;
            r_inflightSop <= 1'b0;
            r_inflightEop <= 1'b0;
        end else begin
            r_state    <= w_nextState;
            r_inflight <= w_issue;
            if (w_issue) begin
                r_inflightSop <= r_first;
                r_inflightEop <= (r_remain == CNT_W'(1));
            end
            if (r_state == IDLE && i_start) begin
                r_addr   <= i_base_addr;
                r_remain <= i_word_count;
                r_first  <= 1'b1;
            end else if (w_issue) begin
                r_addr   <= w_nextAddr;
                r_remain <= r_remain - CNT_W'(1);
                r_first  <= 1'b0;
            end
        end
    end

    // DRAIN may leave while the last beat is being popped, so done follows it by one cycle.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (i_start) w_nextState = (i_word_count == '0) ? FINISH : ISSUE;
            end
            ISSUE: begin
                if (w_issue && r_remain == CNT_W'(1)) w_nextState = DRAIN;
            end
            DRAIN: begin
                if (!r_inflight && (w_empty || (w_count == CW'(1) && w_pop))) w_nextState = FINISH;
            end
            FINISH: w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    mem_reader_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_push  (w_push),
        .i_data  ({r_inflightSop, r_inflightEop, i_mem_readdata}),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    assign o_busy           = (r_state != IDLE);
    assign o_done           = (r_state == FINISH);
    assign o_mem_address    = r_addr;
    assign o_mem_chipselect = w_issue;
    assign o_mem_clken      = 1'b1;
    assign o_mem_write      = 1'b0;
    assign o_mem_byteenable = '1;
    assign o_mem_writedata  = '0;
    assign o_src_data       = w_head[DATA_W-1:0];
    assign o_src_valid      = !w_empty;
    assign o_src_sop        = !w_empty && w_head[DATA_W+1];
    assign o_src_eop        = !w_empty && w_head[DATA_W];

endmodule

// File: tb/tb_onchip_memory_stream_reader.sv
// Directed bench for onchip_memory_stream_reader; the slave model returns word[i] = i.
module tb_onchip_memory_stream_reader;

    localparam int MEMW = 128000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [16:0] baseAddr = '0;
    logic [16:0] wordCount = '0;
    logic        busy, done;
    logic [16:0] memAddress;
    logic        memCs, memClken, memWrite;
    logic [3:0]  memBe;
    logic [31:0] memWdata, memRdata;
    logic [31:0] srcData;
    logic        srcValid, srcSop, srcEop;
    logic        srcReady = 1'b1;

    int vecCount = 0;
    int missCount = 0;
    int cyc = 0;

    logic [16:0] memAddrQ = '0;
    int          csQ[$];
    logic [31:0] beatData[$];
    logic        beatSop[$];
    logic        beatEop[$];
    int          beatCyc[$];
    int          doneCyc[$];
    int          validCycles = 0;
    int          violations = 0;
    int          doneNoBusy = 0;
    int          outstanding = 0;

    onchip_memory_stream_reader dut (
        .i_clk            (clk),
        .i_reset          (reset),
        .i_start          (start),
        .i_base_addr      (baseAddr),
        .i_word_count     (wordCount),
        .o_busy           (busy),
        .o_done           (done),
        .o_mem_address    (memAddress),
        .o_mem_chipselect (memCs),
        .o_mem_clken      (memClken),
        .o_mem_write      (memWrite),
        .o_mem_byteenable (memBe),
        .o_mem_writedata  (memWdata),
        .i_mem_readdata   (memRdata),
        .o_src_data       (srcData),
        .o_src_valid      (srcValid),
        .i_src_ready      (srcReady),
        .o_src_sop        (srcSop),
        .o_src_eop        (srcEop)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Slave model: registered address, unregistered q
    always @(posedge clk) if (memCs) memAddrQ <= memAddress;
    assign memRdata = {15'b0, memAddrQ};

    // Observe the bus at the falling edge, where all inputs have settled for the next rising edge
    always @(negedge clk) begin
        if (reset) begin
            outstanding = 0;
        end else begin
            if (memCs) begin
                csQ.push_back(int'(memAddress));
                if (outstanding >= 4) violations++;
            end
            if (srcValid) validCycles++;
            if (srcValid && srcReady) begin
                beatData.push_back(srcData);
                beatSop.push_back(srcSop);
                beatEop.push_back(srcEop);
                beatCyc.push_back(cyc);
            end
            if (done) begin
                doneCyc.push_back(cyc);
                if (!busy) doneNoBusy++;
            end
            outstanding = outstanding + (memCs ? 1 : 0) - ((srcValid && srcReady) ? 1 : 0);
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vecCount++;
        assert (observed === expected) else begin
            missCount++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic clearLog();
        csQ.delete();
        beatData.delete();
        beatSop.delete();
        beatEop.delete();
        beatCyc.delete();
        doneCyc.delete();
        validCycles = 0;
        violations = 0;
        doneNoBusy = 0;
    endtask

    // Pulse start, then run until done with the chosen ready pattern (mode 1: ready 1,0,0,...).
    // A second start can be pulsed restartAt cycles into the transfer.
    task automatic applyStimulus(input int base, input int count, input int mode, input int restartAt,
                                 output int startCyc, output logic busyAfter);
        clearLog();
        @(posedge clk); #2;
        start = 1'b1;
        baseAddr = 17'(base);
        wordCount = 17'(count);
        srcReady = 1'b1;
        startCyc = cyc;
        @(posedge clk); #2;
        start = 1'b0;
        busyAfter = busy;
        for (int k = 0; k < 300 && doneCyc.size() == 0; k++) begin
            srcReady = (mode == 1) ? (k % 3 == 0) : 1'b1;
            if (k == restartAt) begin
                start = 1'b1;
                baseAddr = 17'h00200;
                wordCount = 17'd3;
            end
            @(posedge clk); #2;
            start = 1'b0;
        end
        srcReady = 1'b1;
        checkOutput("done_seen", 32'(doneCyc.size()), 32'd1);
    endtask

    task automatic checkBlock(input string tag, input int base, input int n);
        int expAddr;
        checkOutput({tag, "_beats"}, 32'(beatData.size()), 32'(n));
        for (int i = 0; i < n && i < beatData.size(); i++) begin
            expAddr = (base + i) % MEMW;
            checkOutput($sformatf("%s_data%0d", tag, i), beatData[i], 32'(expAddr));
            checkOutput($sformatf("%s_sop%0d", tag, i), 32'(beatSop[i]), 32'(i == 0));
            checkOutput($sformatf("%s_eop%0d", tag, i), 32'(beatEop[i]), 32'(i == n - 1));
        end
        checkOutput({tag, "_overissue"}, 32'(violations), 32'd0);
        checkOutput({tag, "_done_busy"}, 32'(doneNoBusy), 32'd0);
    endtask

    initial begin
        int   s;
        logic b;

        $display("[TB] starting");
        repeat (3) @(posedge clk);
        #2;
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_cs", 32'(memCs), 32'd0);
        checkOutput("rst_addr", 32'(memAddress), 32'd0);
        checkOutput("rst_valid", 32'(srcValid), 32'd0);
        checkOutput("rst_sop", 32'(srcSop), 32'd0);
        checkOutput("rst_eop", 32'(srcEop), 32'd0);
        checkOutput("tie_clken", 32'(memClken), 32'd1);
        checkOutput("tie_write", 32'(memWrite), 32'd0);
        checkOutput("tie_be", 32'(memBe), 32'hF);
        checkOutput("tie_wdata", memWdata, 32'd0);
        reset = 1'b0;

        // 1: eight words at full rate
        applyStimulus(32'h10, 8, 0, -1, s, b);
        checkOutput("t1_busy", 32'(b), 32'd1);
        checkBlock("t1", 32'h10, 8);
        if (beatCyc.size() == 8 && doneCyc.size() == 1) begin
            checkOutput("t1_first_lat", 32'(beatCyc[0] - s), 32'd3);
            checkOutput("t1_span", 32'(beatCyc[7] - beatCyc[0]), 32'd7);
            checkOutput("t1_done_lat", 32'(doneCyc[0] - beatCyc[7]), 32'd1);
        end
        checkOutput("t1_idle_busy", 32'(busy), 32'd0);

        // 2: throttled sink
        applyStimulus(32'h20, 6, 1, -1, s, b);
        checkBlock("t2", 32'h20, 6);
        checkOutput("t2_reads", 32'(csQ.size()), 32'd6);

        // 3: address wrap at the top of memory
        applyStimulus(127998, 4, 0, -1, s, b);
        checkBlock("t3", 127998, 4);
        checkOutput("t3_reads", 32'(csQ.size()), 32'd4);
        for (int i = 0; i < 4 && i < csQ.size(); i++)
            checkOutput($sformatf("t3_addr%0d", i), 32'(csQ[i]), 32'((127998 + i) % MEMW));

        // 4: zero-length transfer
        applyStimulus(32'h50, 0, 0, -1, s, b);
        if (doneCyc.size() == 1) checkOutput("t4_done_lat", 32'(doneCyc[0] - s), 32'd1);
        checkOutput("t4_reads", 32'(csQ.size()), 32'd0);
        checkOutput("t4_valid", 32'(validCycles), 32'd0);

        // 5: reset in the middle of a sixteen-word transfer
        clearLog();
        @(posedge clk); #2;
        start = 1'b1;
        baseAddr = 17'h00300;
        wordCount = 17'd16;
        @(posedge clk); #2;
        start = 1'b0;
        repeat (2) begin @(posedge clk); #2; end
        checkOutput("t5_cs_before_rst", 32'(memCs), 32'd1);
        reset = 1'b1;
        @(posedge clk); #2;
        reset = 1'b0;
        checkOutput("t5_busy", 32'(busy), 32'd0);
        checkOutput("t5_valid", 32'(srcValid), 32'd0);
        checkOutput("t5_addr", 32'(memAddress), 32'd0);
        @(posedge clk); #2;
        checkOutput("t5_stale_valid", 32'(srcValid), 32'd0);
        applyStimulus(32'h100, 2, 0, -1, s, b);
        checkBlock("t5", 32'h100, 2);

        // 6: second start while busy is ignored
        applyStimulus(32'h40, 5, 0, 1, s, b);
        repeat (6) begin @(posedge clk); #2; end
        checkBlock("t6", 32'h40, 5);
        checkOutput("t6_reads", 32'(csQ.size()), 32'd5);
        checkOutput("t6_done_count", 32'(doneCyc.size()), 32'd1);
        checkOutput("t6_busy", 32'(busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
